// File: rtl/pgr_fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pgr_fft_pkg
// Brief    : Shared types and constants for the FFT stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pgr_fft_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    FFT_ST_IDLE  = 2'd0,
    FFT_ST_READ  = 2'd1,
    FFT_ST_DRAIN = 2'd2,
    FFT_ST_DONE  = 2'd3
  } fft_state_e;

  // Smallest supported transform is 2^LOG2N_MIN points
  localparam int LOG2N_MIN = 3;

  // Width of the stage index and of the log2(N) configuration field
  localparam int STAGE_W = 4;
  localparam int CFG_W   = 4;

  // True when a requested log2(N) lies inside the supported range
  function automatic logic log2n_legal(input logic [CFG_W-1:0] l, input int max_l);
    return (l >= CFG_W'(LOG2N_MIN)) && (l <= CFG_W'(max_l));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pgr_fft_bfly_addr.sv
`default_nettype none
// ============================================================================
// Module   : pgr_fft_bfly_addr
// Brief    : Combinational butterfly address mapper. For stage s and
//            butterfly index j it yields the A/B operand addresses and the
//            twiddle ROM address of an in-place radix-2 transform.
// Revision : 1.0 - initial release
// ============================================================================
module pgr_fft_bfly_addr
  import pgr_fft_pkg::*;
#(
  parameter int LOG2_N_MAX    = 12,
  parameter int ADDR_WIDTH    = 12,
  parameter int TW_ADDR_WIDTH = 11
) (
  input  logic [STAGE_W-1:0]       stage,
  input  logic [LOG2_N_MAX-1:0]    j,
  input  logic [CFG_W-1:0]         log2n,
  output logic [ADDR_WIDTH-1:0]    addr_a,
  output logic [ADDR_WIDTH-1:0]    addr_b,
  output logic [TW_ADDR_WIDTH-1:0] tw_addr
);

  logic [ADDR_WIDTH-1:0]    w_j;
  logic [ADDR_WIDTH-1:0]    w_span;
  logic [ADDR_WIDTH-1:0]    w_p;
  logic [ADDR_WIDTH-1:0]    w_g_base;
  logic [TW_ADDR_WIDTH-1:0] w_p_tw;
  logic [STAGE_W-1:0]       w_tw_shift;

  // p = j mod 2^s sits in the low bits, the group index g is moved up one
  // bit so that bit s is free; A has bit s clear and B has it set.
  always_comb begin
    w_j        = ADDR_WIDTH'(j);
    w_span     = ADDR_WIDTH'(1) << stage;
    w_p        = w_j & (w_span - ADDR_WIDTH'(1));
    w_g_base   = (w_j >> stage) << (stage + STAGE_W'(1));
    addr_a     = w_g_base | w_p;
    addr_b     = addr_a | w_span;
    w_tw_shift = log2n - stage - STAGE_W'(1);
    w_p_tw     = TW_ADDR_WIDTH'(w_p);
    tw_addr    = w_p_tw << w_tw_shift;
  end

endmodule
`default_nettype wire

// File: rtl/pgr_fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pgr_fft_stage_ctrl
// Brief    : Stage sequencer for the burst in-place radix-2 FFT engine.
//            Walks all log2(N) stages, issues one butterfly per cycle and
//            inserts a PIPE_LAT drain gap between stages so a stage never
//            reads data the previous stage has not written back.
// Revision : 1.0 - initial release
// ============================================================================
module pgr_fft_stage_ctrl
  import pgr_fft_pkg::*;
#(
  parameter int LOG2_N_MAX    = 12,
  parameter int ADDR_WIDTH    = 12,
  parameter int TW_ADDR_WIDTH = 11,
  parameter int PIPE_LAT      = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CFG_W-1:0]         cfg_log2n,
  input  logic                     stall,
  output logic                     ready,
  output logic                     busy,
  output logic                     rd_valid,
  output logic [ADDR_WIDTH-1:0]    rd_addr_a,
  output logic [ADDR_WIDTH-1:0]    rd_addr_b,
  output logic [TW_ADDR_WIDTH-1:0] tw_addr,
  output logic                     first_level,
  output logic [STAGE_W-1:0]       stage,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int J_W   = LOG2_N_MAX;
  localparam int DRN_W = 6;

  fft_state_e          r_state;
  logic [CFG_W-1:0]    r_log2n;
  logic [J_W-1:0]      r_j;
  logic [DRN_W-1:0]    r_drain;

  logic [J_W-1:0]      w_j_nxt;
  logic [STAGE_W-1:0]  w_stage_nxt;
  logic [CFG_W-1:0]    w_log2n_nxt;
  logic [J_W-1:0]      w_last_j;
  logic                w_cfg_ok;
  logic                w_last_issue;
  logic                w_drain_end;
  logic                w_more_stages;

  logic [ADDR_WIDTH-1:0]    w_addr_a;
  logic [ADDR_WIDTH-1:0]    w_addr_b;
  logic [TW_ADDR_WIDTH-1:0] w_tw_addr;

  // Addresses are computed for the index that will be presented next cycle,
  // so the registered outputs line up with rd_valid and first_level.
  pgr_fft_bfly_addr #(
    .LOG2_N_MAX    (LOG2_N_MAX),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TW_ADDR_WIDTH (TW_ADDR_WIDTH)
  ) u_bfly_addr (
    .stage   (w_stage_nxt),
    .j       (w_j_nxt),
    .log2n   (w_log2n_nxt),
    .addr_a  (w_addr_a),
    .addr_b  (w_addr_b),
    .tw_addr (w_tw_addr)
  );

  // Next butterfly index, stage and transform size for the upcoming cycle
  always_comb begin
    w_cfg_ok      = log2n_legal(cfg_log2n, LOG2_N_MAX);
    w_last_j      = (J_W'(1) << (r_log2n - CFG_W'(1))) - J_W'(1);
    w_last_issue  = rd_valid && (r_j == w_last_j);
    w_drain_end   = (r_drain == DRN_W'(1));
    w_more_stages = (stage < (r_log2n - CFG_W'(1)));
    w_j_nxt       = r_j;
    w_stage_nxt   = stage;
    w_log2n_nxt   = r_log2n;
    case (r_state)
      FFT_ST_IDLE: begin
        if (start && w_cfg_ok) begin
          w_j_nxt     = '0;
          w_stage_nxt = '0;
          w_log2n_nxt = cfg_log2n;
        end
      end
      FFT_ST_READ: begin
        if (rd_valid && !w_last_issue) begin
          w_j_nxt = r_j + J_W'(1);
        end
      end
      FFT_ST_DRAIN: begin
        if (w_drain_end && w_more_stages) begin
          w_j_nxt     = '0;
          w_stage_nxt = stage + STAGE_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with all outputs registered. rd_valid for the next cycle
  // is taken from stall at this edge; a stalled slot re-presents the same
  // addresses because the index only moves on an issued butterfly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FFT_ST_IDLE;
      r_log2n     <= '0;
      r_j         <= '0;
      r_drain     <= '0;
      stage       <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      first_level <= 1'b0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      tw_addr     <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      r_j     <= w_j_nxt;
      stage   <= w_stage_nxt;
      r_log2n <= w_log2n_nxt;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (r_state)
        FFT_ST_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_state     <= FFT_ST_READ;
              ready       <= 1'b0;
              busy        <= 1'b1;
              rd_valid    <= ~stall;
              first_level <= ~stall;
              rd_addr_a   <= w_addr_a;
              rd_addr_b   <= w_addr_b;
              tw_addr     <= w_tw_addr;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        FFT_ST_READ: begin
          if (w_last_issue) begin
            r_state     <= FFT_ST_DRAIN;
            r_drain     <= DRN_W'(PIPE_LAT);
            rd_valid    <= 1'b0;
            first_level <= 1'b0;
          end else begin
            rd_valid    <= ~stall;
            first_level <= ~stall && (w_stage_nxt == STAGE_W'(0));
            rd_addr_a   <= w_addr_a;
            rd_addr_b   <= w_addr_b;
            tw_addr     <= w_tw_addr;
          end
        end
        FFT_ST_DRAIN: begin
          r_drain <= r_drain - DRN_W'(1);
          if (w_drain_end) begin
            if (w_more_stages) begin
              r_state     <= FFT_ST_READ;
              rd_valid    <= ~stall;
              first_level <= 1'b0;
              rd_addr_a   <= w_addr_a;
              rd_addr_b   <= w_addr_b;
              tw_addr     <= w_tw_addr;
            end else begin
              r_state <= FFT_ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        FFT_ST_DONE: begin
          r_state <= FFT_ST_IDLE;
          ready   <= 1'b1;
        end
        default: r_state <= FFT_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pgr_fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgr_fft_stage_ctrl
// Brief    : Self-checking bench for the FFT stage sequencer. Expected
//            butterflies come from a block/offset view of the transform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgr_fft_stage_ctrl;

  localparam int LOG2_N_MAX    = 12;
  localparam int ADDR_WIDTH    = 12;
  localparam int TW_ADDR_WIDTH = 11;
  localparam int PIPE_LAT      = 6;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [3:0]               cfg_log2n;
  logic                     stall;
  logic                     ready;
  logic                     busy;
  logic                     rd_valid;
  logic [ADDR_WIDTH-1:0]    rd_addr_a;
  logic [ADDR_WIDTH-1:0]    rd_addr_b;
  logic [TW_ADDR_WIDTH-1:0] tw_addr;
  logic                     first_level;
  logic [3:0]               stage;
  logic                     done;
  logic                     cfg_err;

  pgr_fft_stage_ctrl #(
    .LOG2_N_MAX    (LOG2_N_MAX),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TW_ADDR_WIDTH (TW_ADDR_WIDTH),
    .PIPE_LAT      (PIPE_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_log2n   (cfg_log2n),
    .stall       (stall),
    .ready       (ready),
    .busy        (busy),
    .rd_valid    (rd_valid),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_addr     (tw_addr),
    .first_level (first_level),
    .stage       (stage),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
  } iss_t;

  iss_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  int   t0 = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   issue_cnt = 0;
  int   last_a = -1;
  int   last_b = -1;
  int   last_tw = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Butterflies in issue order: per stage, walk blocks of 2^(s+1) points;
  // inside a block the k-th butterfly pairs k with k+2^s and uses twiddle
  // k*N/2^(s+1).
  function automatic void build_model(input int l2);
    int   n;
    int   half;
    int   span;
    iss_t e;
    exp_q.delete();
    n = 1 << l2;
    for (int s = 0; s < l2; s++) begin
      half = 1 << s;
      span = 2 * half;
      for (int base = 0; base < n; base += span) begin
        for (int k = 0; k < half; k++) begin
          e.a  = base + k;
          e.b  = base + k + half;
          e.tw = k * (n / span);
          e.s  = s;
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  // Compare process: every issued butterfly against the model
  always @(negedge clk) begin
    iss_t e;
    if (armed) begin
      if (rd_valid) begin
        issue_cnt++;
        last_a  = int'(rd_addr_a);
        last_b  = int'(rd_addr_b);
        last_tw = int'(tw_addr);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL issue_overrun: got issue a=%0d, expected no further issue", rd_addr_a);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr_a", 32'(rd_addr_a), e.a);
          chk("rd_addr_b", 32'(rd_addr_b), e.b);
          chk("tw_addr", 32'(tw_addr), e.tw);
          chk("stage", 32'(stage), e.s);
          chk("first_level", 32'(first_level), (e.s == 0) ? 1 : 0);
        end
      end else begin
        chk("first_level_idle", 32'(first_level), 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      chk("ready_busy_excl", 32'(ready & busy), 0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_addr_a"}, 32'(rd_addr_a), 0);
    chk({tag, "_addr_b"}, 32'(rd_addr_b), 0);
    chk({tag, "_tw"}, 32'(tw_addr), 0);
    chk({tag, "_first"}, 32'(first_level), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  // One transform. Stall input is held high in cycles st_lo-1..st_hi-1 so
  // that rd_valid is low in cycles st_lo..st_hi, where the addresses must
  // hold at (sa,sb). p1/p2 are spurious start cycles; abort_at pulls reset.
  task automatic run(input int l2, input int st_lo, input int st_hi,
                     input int sa, input int sb, input int p1, input int p2,
                     input int abort_at, input int exp_done);
    int  n2;
    bit  aborted;
    n2      = 1 << (l2 - 1);
    aborted = 1'b0;
    build_model(l2);
    @(negedge clk);
    t0        = cyc;
    done_cnt  = 0;
    done_cyc  = -1;
    issue_cnt = 0;
    armed     = 1'b1;
    cfg_log2n = 4'(l2);
    for (int k = 0; k <= exp_done + 2; k++) begin
      if (k > 0) @(negedge clk);
      start = (k == 0) || (k == p1) || (k == p2);
      stall = (st_lo > 0) && (k >= st_lo - 1) && (k <= st_hi - 1);
      if (st_lo > 0 && k >= st_lo && k <= st_hi) begin
        chk("stall_rd_valid", 32'(rd_valid), 0);
        chk("stall_hold_a", 32'(rd_addr_a), sa);
        chk("stall_hold_b", 32'(rd_addr_b), sb);
      end
      if (k == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        armed = 1'b0;
        chk_reset_vals("abort");
        exp_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (!aborted) begin
      chk("done_count", done_cnt, 1);
      chk("done_cycle", done_cyc, exp_done);
      chk("issues_total", issue_cnt, n2 * l2);
      chk("model_drained", exp_q.size(), 0);
      chk("ready_after", 32'(ready), 1);
    end
    armed = 1'b0;
  endtask

  task automatic bad_cfg(input int l2);
    @(negedge clk);
    start     = 1'b1;
    cfg_log2n = 4'(l2);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_ready", 32'(ready), 1);
    chk("cfg_err_no_valid", 32'(rd_valid), 0);
    chk("cfg_err_not_busy", 32'(busy), 0);
    @(negedge clk);
    chk("cfg_err_clear", 32'(cfg_err), 0);
    chk("cfg_err_no_valid2", 32'(rd_valid), 0);
  endtask

  function automatic int done_at(input int l2, input int nstall);
    return l2 * ((1 << (l2 - 1)) + PIPE_LAT) + 1 + nstall;
  endfunction

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    cfg_log2n = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Pin the model against hand-computed N=8 butterflies
    build_model(3);
    chk("model_s0_j1_a", exp_q[1].a, 2);
    chk("model_s0_j3_b", exp_q[3].b, 7);
    chk("model_s1_j1_b", exp_q[5].b, 3);
    chk("model_s1_j1_tw", exp_q[5].tw, 2);
    chk("model_s1_j3_a", exp_q[7].a, 5);
    chk("model_s2_j0_b", exp_q[8].b, 4);
    chk("model_s2_j3_a", exp_q[11].a, 3);
    chk("model_s2_j3_tw", exp_q[11].tw, 3);
    exp_q.delete();

    // N=8 plain, stalled, and with ignored starts while busy
    run(3, 0, 0, 0, 0, -1, -1, -1, 31);
    run(3, 2, 4, 2, 3, -1, -1, -1, 34);
    run(3, 0, 0, 0, 0, 5, 20, -1, 31);

    // Illegal sizes are rejected
    bad_cfg(2);
    bad_cfg(13);
    bad_cfg(0);

    // Reset mid-run, then a clean run
    run(3, 0, 0, 0, 0, -1, -1, 10, 31);
    run(3, 0, 0, 0, 0, -1, -1, -1, 31);

    // Other sizes, including a stall in a wider transform
    run(4, 0, 0, 0, 0, -1, -1, -1, done_at(4, 0));
    run(5, 3, 7, 4, 5, -1, -1, -1, done_at(5, 5));

    // Largest transform
    run(LOG2_N_MAX, 0, 0, 0, 0, -1, -1, -1, done_at(LOG2_N_MAX, 0));
    chk("max_last_a", last_a, 2047);
    chk("max_last_b", last_b, 4095);
    chk("max_last_tw", last_tw, 2047);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
